// File: rtl/mult_div.sv
// rtl/mult_div.sv - 32-bit multiply/divide unit with HI/LO registers and 33-cycle iterative datapath.
// Define MULT_DIV_FAST_MUL_EN for single-cycle MULT/MULTU; divides always iterate.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] acc_hi, acc_lo, opnd;
  logic        op_div, neg_res, neg_rem, div_zero;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic        fast_mul;

  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[31]) ? -a : a;
  assign b_mag     = (signed_op && b[31]) ? -b : b;

`ifdef MULT_DIV_FAST_MUL_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign fast_mul  = ~op[1];
  assign ext_a     = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
  assign ext_b     = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
  // Low 64 bits of the sign-extended product equal the signed product.
  assign fast_prod = ext_a * ext_b;
`else
  assign fast_mul  = 1'b0;
`endif

  // Iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [32:0] mul_add;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  assign mul_add   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift[31:0] - opnd;

  // Sign correction; a zero divisor leaves the raw dividend in the remainder naturally
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !fast_mul) state_nxt = ITER;
      ITER:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      cnt      <= 5'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd     <= 32'd0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MULT_DIV_FAST_MUL_EN
            if (fast_mul) begin
              {hi, lo} <= fast_prod;
              done     <= 1'b1;
            end
`endif
            op_div   <= op[1];
            neg_res  <= signed_op & (a[31] ^ b[31]);
            neg_rem  <= signed_op & a[31];
            div_zero <= (b == 32'd0);
            acc_hi   <= 32'd0;
            cnt      <= 5'd0;
            // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier out.
            opnd     <= op[1] ? b_mag : a_mag;
            acc_lo   <= op[1] ? a_mag : b_mag;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (op_div) begin
            acc_hi <= div_ge ? div_sub : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_add, acc_lo[31:1]};
          end
        end
        FIX: begin
          cnt  <= 5'd0;
          done <= 1'b1;
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - randomized self-checking bench for mult_div against an arithmetic reference.
module tb_mult_div;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Reference: an accepted op lands its result 33 edges later; moves land at the next edge.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  logic        m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (start) begin
        {p_hi, p_lo} <= ref_op(op, a, b);
`ifdef MULT_DIV_FAST_MUL_EN
        if (!op[1]) begin
          {m_hi, m_lo} <= ref_op(op, a, b);
          m_done <= 1'b1;
        end else m_left <= 33;
`else
        m_left <= 33;
`endif
      end else begin
        if (mthi) m_hi <= a;
        if (mtlo) m_lo <= a;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("done", {31'd0, done}, {31'd0, m_done});
  end

  // Issue an op at the current negedge and return at the negedge where done is high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic with_mtlo);
    op = o; a = x; b = y; start = 1'b1; mtlo = with_mtlo;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'd0, -32'sd7, 32'd6, 1'b0);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFD6);
    run_op(2'd2, -32'sd7, 32'd2, 1'b0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);
    run_op(2'd3, 32'd100, 32'd0, 1'b0);
    check("divu_z_lo", lo, 32'hFFFF_FFFF);
    check("divu_z_hi", hi, 32'd100);
    run_op(2'd2, -32'sd5, 32'd0, 1'b0);
    check("div_z_hi", hi, 32'hFFFF_FFFB);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; a = 32'd9;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mv_hi", hi, 32'd9);
    check("mv_lo", lo, 32'd9);

    op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mthi = 1'b1; a = 32'd5; start = 1'b1; op = 2'd3;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("busy_mthi_hi", hi, 32'd0);
    check("busy_mthi_lo", lo, 32'd42);

    run_op(2'd1, 32'd11, 32'd3, 1'b1);
    check("start_mtlo_lo", lo, 32'd33);

    op = 2'd1; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    reset = 1'b1;
    repeat (36) @(negedge clk);
    check("rst_no_result", lo, 32'd0);
    run_op(2'd1, 32'd3, 32'd4, 1'b0);
    check("after_rst_lo", lo, 32'd12);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom; mthi = $urandom_range(0, 1); mtlo = $urandom_range(0, 1);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
      end
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
